// File: rtl/timer_ten.sv
// One decimal digit of the countdown timer: loadable, enabled mod-MOD down-counter with borrow.
// Optional macro TIMER_TEN_LOAD_CLAMP_EN: out-of-range loads clamp to MOD-1 instead of loading 0.
module timer_ten #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MOD   = 10
) (
   input  logic [WIDTH-1:0] in,
   input  logic             loadn,
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             zero
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] load_val;
   logic             cnt_zero;

   // Loads beyond the modulus are folded back so out never leaves 0..MOD-1.
   always_comb begin
      load_val = in;
      if (in > MaxVal) begin
`ifdef TIMER_TEN_LOAD_CLAMP_EN
         load_val = MaxVal;
`else
         load_val = '0;
`endif
      end
   end

   assign cnt_zero = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (!loadn) begin
         cnt_d = load_val;
      end else if (en) begin
         cnt_d = cnt_zero ? MaxVal : cnt_q - 1'b1;
      end
   end

   // clrn is active-high despite its name.
   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign out  = cnt_q;
   assign zero = cnt_zero;
   assign tc   = en & cnt_zero;

endmodule

// File: tb/tb_timer_ten.sv
// Self-checking bench for timer_ten: directed sequences, a vector table and a random run
// against a plain-arithmetic reference model.
module tb_timer_ten;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
`ifdef TIMER_TEN_LOAD_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif

   logic [WIDTH-1:0] in;
   logic             loadn, clk, clrn, en;
   logic [WIDTH-1:0] out;
   logic             tc, zero;

   int n_checks = 0;
   int n_pass   = 0;

   timer_ten #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .in    (in),
      .loadn (loadn),
      .clk   (clk),
      .clrn  (clrn),
      .en    (en),
      .out   (out),
      .tc    (tc),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       loadn;
      logic       en;
      logic [3:0] in;
      int         exp_out;
   } vec_t;

   vec_t vecs[10];

   function automatic int load_result(input int v);
      if (v <= MOD - 1) return v;
      return CLAMP ? MOD - 1 : 0;
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic check_all(input string name, input int exp_out, input bit cur_en);
      check({name, ".out"}, int'(out), exp_out);
      check({name, ".zero"}, int'(zero), (exp_out == 0) ? 1 : 0);
      check({name, ".tc"}, int'(tc), (cur_en && exp_out == 0) ? 1 : 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int model;
   int exp_seq[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 9, 8};

   initial begin
      in = '0; loadn = 1'b1; en = 1'b0; clrn = 1'b1;
      #2;
      check_all("reset_en0", 0, 1'b0);
      en = 1'b1;
      #1;
      check_all("reset_en1", 0, 1'b1);
      step();
      check_all("reset_held_edge", 0, 1'b1);
      en = 1'b0;
      #2 clrn = 1'b0;

      // Load 8, count down through the wrap.
      loadn = 1'b0; in = 4'd8; en = 1'b0;
      step();
      check_all("load8", 8, 1'b0);
      loadn = 1'b1; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (exp_seq[i] == 9) check_all("pre_wrap", 0, 1'b1);
         step();
         check_all($sformatf("count_%0d", i), exp_seq[i], 1'b1);
      end

      // Asynchronous reset mid-count at out=5.
      loadn = 1'b0; in = 4'd5;
      step();
      check_all("load5", 5, 1'b1);
      loadn = 1'b1;
      #2 clrn = 1'b1;
      #1 check_all("async_clr", 0, 1'b1);
      step();
      check_all("clr_hold1", 0, 1'b1);
      loadn = 1'b0; in = 4'd7;
      step();
      check_all("clr_over_load", 0, 1'b1);
      loadn = 1'b1;
      #2 clrn = 1'b0;
      step();
      check_all("resume_from_0", 9, 1'b1);

      // Enable low holds.
      loadn = 1'b0; in = 4'd3;
      step();
      loadn = 1'b1; en = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_all("hold3", 3, 1'b0);
      loadn = 1'b0; in = 4'd0;
      step();
      loadn = 1'b1;
      step();
      check_all("hold0_tc_low", 0, 1'b0);

      // Load beats count, even at out=0 with en=1.
      en = 1'b1; loadn = 1'b0; in = 4'd4;
      #1 check_all("pre_load_prio", 0, 1'b1);
      step();
      check_all("load_prio", 4, 1'b1);
      in = 4'd15;
      step();
      check_all("oor_load15", load_result(15), 1'b1);
      loadn = 1'b1;

      // Vector table, starting from a known 0.
      loadn = 1'b0; in = 4'd0; en = 1'b0;
      step();
      vecs[0] = '{1'b0, 1'b0, 4'd2,  2};
      vecs[1] = '{1'b1, 1'b1, 4'd6,  1};
      vecs[2] = '{1'b1, 1'b1, 4'd6,  0};
      vecs[3] = '{1'b1, 1'b0, 4'd1,  0};
      vecs[4] = '{1'b1, 1'b1, 4'd1,  9};
      vecs[5] = '{1'b0, 1'b0, 4'd12, load_result(12)};
      vecs[6] = '{1'b0, 1'b1, 4'd9,  9};
      vecs[7] = '{1'b0, 1'b1, 4'd0,  0};
      vecs[8] = '{1'b1, 1'b1, 4'd0,  9};
      vecs[9] = '{1'b0, 1'b0, 4'd10, load_result(10)};
      foreach (vecs[i]) begin
         loadn = vecs[i].loadn; en = vecs[i].en; in = vecs[i].in;
         step();
         check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].en);
      end

      // Random run against the arithmetic model.
      model = int'(out);
      for (int i = 0; i < 400; i++) begin
         loadn = ($urandom_range(0, 3) != 0);
         en    = $urandom_range(0, 1);
         in    = WIDTH'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) begin
            clrn = 1'b1;
            model = 0;
            #1 check_all($sformatf("rnd_clr%0d", i), model, en);
            #1 clrn = 1'b0;
         end
         if (!loadn) model = load_result(int'(in));
         else if (en) model = (model + MOD - 1) % MOD;
         step();
         check_all($sformatf("rnd%0d", i), model, en);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
